sim_finish_monitor: RTL and testbench

Multi-hart test-completion monitor for the SOPHON simulation environment. It watches each hart's ecall strobe and `gp` (x3) value and waits for every hart to finish. After a programmable drain window it reports pass, fail or timeout with a registered, sticky verdict. It is synthesizable so the same checker serves Verilator, event-driven simulators and FPGA bring-up, where `$display`/`$finish` are driven from its outputs by a thin wrapper.

---
 rtl/sim_finish_monitor_pkg.sv | 20 ++
 rtl/sim_finish_monitor_if.sv | 33 +++
 rtl/sim_finish_hart_slot.sv | 27 ++
 rtl/sim_finish_monitor.sv | 132 +++++++++++++
 tb/tb_sim_finish_monitor.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_finish_monitor_pkg.sv
// Shared verification package for the SOPHON simulation environment.
// Holds the finish-monitor FSM state type, default monitor timing constants
// and a helper for sizing hart index fields.
package SOPHON_VRF_PKG;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } finish_state_e;

   localparam int DEF_TO_BIT       = 18;
   localparam int DEF_DRAIN_CYCLES = 255;

   // Width of a hart index; a single hart still gets a 1-bit field.
   function automatic int hart_idx_w(input int num_hart);
      return (num_hart > 1) ? $clog2(num_hart) : 1;
   endfunction

endpackage

// File: rtl/sim_finish_monitor_if.sv
// Bus between the harts under test and the finish monitor.
// Ports: ecall_i/gp_i flow from the harts (master) to the monitor (slave);
// done/pass/fail/timeout, failing hart/code and the cycle counter flow back.
interface sim_finish_monitor_if
   import SOPHON_VRF_PKG::*;
#(
   parameter int NUM_HART = 1,
   parameter int XLEN     = 32,
   parameter int TO_BIT   = DEF_TO_BIT
);
   localparam int HW = hart_idx_w(NUM_HART);

   logic [NUM_HART-1:0]      ecall_i;
   logic [NUM_HART*XLEN-1:0] gp_i;
   logic                     done_o;
   logic                     pass_o;
   logic                     fail_o;
   logic                     timeout_o;
   logic [HW-1:0]            fail_hart_o;
   logic [XLEN-2:0]          fail_code_o;
   logic [TO_BIT-1:0]        cycle_cnt_o;

   modport master (
      output ecall_i, gp_i,
      input  done_o, pass_o, fail_o, timeout_o, fail_hart_o, fail_code_o, cycle_cnt_o
   );

   modport slave (
      input  ecall_i, gp_i,
      output done_o, pass_o, fail_o, timeout_o, fail_hart_o, fail_code_o, cycle_cnt_o
   );

endinterface

// File: rtl/sim_finish_hart_slot.sv
// Per-hart completion slot: remembers that the hart issued its ecall and keeps
// the gp value seen in that same cycle. Ports: clk/rst, ecall/gp from the hart,
// hold freezes the slot, seen/gp_q report the captured state.
module sim_finish_hart_slot #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ecall,
   input  logic [XLEN-1:0] gp,
   input  logic            hold,
   output logic            seen,
   output logic [XLEN-1:0] gp_q
);

   // Only the first ecall counts; later ones (and later gp changes) are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         seen <= 1'b0;
         gp_q <= '0;
      end else if (ecall && !seen && !hold) begin
         seen <= 1'b1;
         gp_q <= gp;
      end
   end

endmodule

// File: rtl/sim_finish_monitor.sv
// Multi-hart test-completion monitor: waits for every hart's ecall, drains for
// DRAIN_CYCLES, then reports a sticky registered pass/fail/timeout verdict.
// Ports: clk_i, rst_i (sync, active-high) and the slave side of the monitor bus.
module sim_finish_monitor
   import SOPHON_VRF_PKG::*;
#(
   parameter int NUM_HART     = 1,
   parameter int XLEN         = 32,
   parameter int TO_BIT       = DEF_TO_BIT,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
   input logic                  clk_i,
   input logic                  rst_i,
   sim_finish_monitor_if.slave  bus
);

   localparam int HW = hart_idx_w(NUM_HART);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

   finish_state_e       state;
   logic [TO_BIT-1:0]   timeout_cnt;
   logic [DW-1:0]       drain_cnt;
   logic [NUM_HART-1:0] seen;
   logic [XLEN-1:0]     gp_q [NUM_HART];
   logic [NUM_HART-1:0] seen_nxt;
   logic [NUM_HART-1:0] gp_bad;
   logic                frozen;
   logic [HW-1:0]       bad_idx;
   logic [XLEN-2:0]     bad_code;
   logic [HW-1:0]       unseen_idx;

   logic            done_r;
   logic            pass_r;
   logic            fail_r;
   logic            timeout_r;
   logic [HW-1:0]   fail_hart_r;
   logic [XLEN-2:0] fail_code_r;

   assign frozen = (state == DONE);

   for (genvar h = 0; h < NUM_HART; h++) begin : g_slot
      sim_finish_hart_slot #(.XLEN(XLEN)) u_slot (
         .clk   (clk_i),
         .rst   (rst_i),
         .ecall (bus.ecall_i[h]),
         .gp    (bus.gp_i[h*XLEN +: XLEN]),
         .hold  (frozen),
         .seen  (seen[h]),
         .gp_q  (gp_q[h])
      );
      assign gp_bad[h] = (gp_q[h] != XLEN'(1));
   end

   // Seen set as it will be after this edge, so a same-cycle ecall counts.
   assign seen_nxt = seen | bus.ecall_i;

   // Priority encoders: scanning downwards leaves the lowest matching hart.
   always_comb begin
      bad_idx    = '0;
      bad_code   = '0;
      unseen_idx = '0;
      for (int h = NUM_HART - 1; h >= 0; h--) begin
         if (gp_bad[h]) begin
            bad_idx  = HW'(h);
            bad_code = gp_q[h][XLEN-1:1];
         end
         if (!seen_nxt[h]) begin
            unseen_idx = HW'(h);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= RUN;
         timeout_cnt <= '0;
         drain_cnt   <= '0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
         timeout_r   <= 1'b0;
         fail_hart_r <= '0;
         fail_code_r <= '0;
      end else begin
         case (state)
            RUN: begin
               if (timeout_cnt != '1) begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
               // Completion takes priority over a timeout on the same edge.
               if (&seen_nxt) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else if (&timeout_cnt) begin
                  state       <= DONE;
                  done_r      <= 1'b1;
                  timeout_r   <= 1'b1;
                  fail_hart_r <= unseen_idx;
                  fail_code_r <= '0;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
               if (drain_cnt == DRAIN_LAST) begin
                  state  <= DONE;
                  done_r <= 1'b1;
                  if (|gp_bad) begin
                     fail_r      <= 1'b1;
                     fail_hart_r <= bad_idx;
                     fail_code_r <= bad_code;
                  end else begin
                     pass_r <= 1'b1;
                  end
               end
            end
            default: begin
               // DONE: everything holds until reset.
            end
         endcase
      end
   end

   assign bus.done_o      = done_r;
   assign bus.pass_o      = pass_r;
   assign bus.fail_o      = fail_r;
   assign bus.timeout_o   = timeout_r;
   assign bus.fail_hart_o = fail_hart_r;
   assign bus.fail_code_o = fail_code_r;
   assign bus.cycle_cnt_o = timeout_cnt;

endmodule

// File: tb/tb_sim_finish_monitor.sv
// Bench for sim_finish_monitor: two instances (2 harts / drain 4, 4 harts / drain 3,
// both with a 6-bit timeout) driven by directed scenarios, checked every cycle
// against an event-time model and at key points against hand-computed values.
module tb_sim_finish_monitor;

   localparam int NDUT = 2;
   localparam int TLIM = 64;          // timeout fires on edge 2^6
   localparam int CMAX = 63;          // saturated 6-bit counter
   localparam int NH [NDUT] = '{2, 4};
   localparam int DC [NDUT] = '{4, 3};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]  ec  [NDUT];
   logic [31:0] gpv [NDUT][4];

   sim_finish_monitor_if #(.NUM_HART(2), .XLEN(32), .TO_BIT(6)) bus_a ();
   sim_finish_monitor_if #(.NUM_HART(4), .XLEN(32), .TO_BIT(6)) bus_b ();

   assign bus_a.ecall_i = ec[0][1:0];
   assign bus_a.gp_i    = {gpv[0][1], gpv[0][0]};
   assign bus_b.ecall_i = ec[1];
   assign bus_b.gp_i    = {gpv[1][3], gpv[1][2], gpv[1][1], gpv[1][0]};

   sim_finish_monitor #(.NUM_HART(2), .XLEN(32), .TO_BIT(6), .DRAIN_CYCLES(4)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_a)
   );

   sim_finish_monitor #(.NUM_HART(4), .XLEN(32), .TO_BIT(6), .DRAIN_CYCLES(3)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- model: edges since reset, first-ecall data per hart,
   // and the edge on which the last hart completed (-1 if not yet).
   int          m_k    [NDUT];
   int          m_comp [NDUT];
   bit          m_seen [NDUT][4];
   logic [31:0] m_gp   [NDUT][4];
   bit          armed = 1'b0;

   always @(posedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (rst) begin
            m_k[d]    = 0;
            m_comp[d] = -1;
            for (int h = 0; h < 4; h++) begin
               m_seen[d][h] = 1'b0;
               m_gp[d][h]   = '0;
            end
         end else begin
            m_k[d]++;
            if (m_comp[d] < 0 && m_k[d] <= TLIM) begin
               bit all;
               all = 1'b1;
               for (int h = 0; h < NH[d]; h++) begin
                  if (ec[d][h] && !m_seen[d][h]) begin
                     m_seen[d][h] = 1'b1;
                     m_gp[d][h]   = gpv[d][h];
                  end
                  if (!m_seen[d][h]) all = 1'b0;
               end
               if (all) m_comp[d] = m_k[d];
            end
         end
      end
      if (rst) armed = 1'b1;
   end

   task automatic cmp(input int d, input logic done, input logic pass, input logic fail,
                      input logic to, input logic [7:0] fh, input logic [30:0] fc,
                      input logic [5:0] cc);
      logic       e_done, e_pass, e_fail, e_to;
      int         e_fh, e_cc;
      logic [30:0] e_fc;
      e_done = 0; e_pass = 0; e_fail = 0; e_to = 0; e_fh = 0; e_fc = '0; e_cc = 0;
      if (m_comp[d] >= 0) begin
         e_cc = (m_comp[d] > CMAX) ? CMAX : m_comp[d];
         if (m_k[d] >= m_comp[d] + DC[d]) begin
            e_done = 1;
            e_pass = 1;
            for (int h = NH[d] - 1; h >= 0; h--) begin
               if (m_gp[d][h] != 32'd1) begin
                  e_pass = 0;
                  e_fail = 1;
                  e_fh   = h;
                  e_fc   = m_gp[d][h][31:1];
               end
            end
         end
      end else if (m_k[d] >= TLIM) begin
         e_done = 1;
         e_to   = 1;
         e_cc   = CMAX;
         for (int h = NH[d] - 1; h >= 0; h--)
            if (!m_seen[d][h]) e_fh = h;
      end else begin
         e_cc = m_k[d];
      end
      chk($sformatf("dut%0d.done k=%0d", d, m_k[d]), done, e_done);
      chk($sformatf("dut%0d.pass k=%0d", d, m_k[d]), pass, e_pass);
      chk($sformatf("dut%0d.fail k=%0d", d, m_k[d]), fail, e_fail);
      chk($sformatf("dut%0d.timeout k=%0d", d, m_k[d]), to, e_to);
      chk($sformatf("dut%0d.fail_hart k=%0d", d, m_k[d]), fh, e_fh);
      chk($sformatf("dut%0d.fail_code k=%0d", d, m_k[d]), fc, e_fc);
      chk($sformatf("dut%0d.cycle_cnt k=%0d", d, m_k[d]), cc, e_cc);
   endtask

   always @(negedge clk) begin
      if (armed) begin
         cmp(0, bus_a.done_o, bus_a.pass_o, bus_a.fail_o, bus_a.timeout_o,
             8'(bus_a.fail_hart_o), bus_a.fail_code_o, bus_a.cycle_cnt_o);
         cmp(1, bus_b.done_o, bus_b.pass_o, bus_b.fail_o, bus_b.timeout_o,
             8'(bus_b.fail_hart_o), bus_b.fail_code_o, bus_b.cycle_cnt_o);
      end
   end

   // ---------------- stimulus helpers; "now" is always 1 time unit after an edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   // Ecall presented now is sampled on the next edge.
   task automatic pulse(input int d, input int h, input logic [31:0] g);
      ec[d][h]  = 1'b1;
      gpv[d][h] = g;
      step(1);
      ec[d][h]  = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         ec[d] = '0;
         for (int h = 0; h < 4; h++) gpv[d][h] = '0;
      end
      #1;
      step(2);
      do_reset();
      chk("reset.done", bus_a.done_o, 0);
      chk("reset.cycle_cnt", bus_a.cycle_cnt_o, 0);

      // Two-hart pass: last ecall sampled at edge 21 -> DRAIN, verdict after edge 25.
      step(10);
      pulse(0, 0, 32'd1);
      step(9);
      pulse(0, 1, 32'd1);
      chk("pass.cycle_cnt_e21", bus_a.cycle_cnt_o, 21);
      step(3);
      chk("pass.done_e24", bus_a.done_o, 0);
      step(1);
      chk("pass.done_e25", bus_a.done_o, 1);
      chk("pass.pass_e25", bus_a.pass_o, 1);
      step(3);

      // Single-hart fail, then later gp changes and repeat ecalls.
      do_reset();
      step(5);
      pulse(0, 0, 32'd1);
      step(2);
      pulse(0, 1, 32'd7);
      pulse(0, 1, 32'd9);
      pulse(0, 0, 32'd3);
      gpv[0][1] = 32'd1;
      step(10);
      chk("fail.fail", bus_a.fail_o, 1);
      chk("fail.pass", bus_a.pass_o, 0);
      chk("fail.fail_hart", bus_a.fail_hart_o, 1);
      chk("fail.fail_code", bus_a.fail_code_o, 3);

      // Timeout: only hart0 finishes.
      do_reset();
      step(3);
      pulse(0, 0, 32'd1);
      step(59);
      chk("to.done_e63", bus_a.done_o, 0);
      chk("to.cycle_cnt_e63", bus_a.cycle_cnt_o, 63);
      step(1);
      chk("to.timeout_e64", bus_a.timeout_o, 1);
      chk("to.fail_hart_e64", bus_a.fail_hart_o, 1);
      chk("to.cycle_cnt_e64", bus_a.cycle_cnt_o, 63);
      step(3);
      pulse(0, 1, 32'd1);
      step(6);
      chk("to.sticky_timeout", bus_a.timeout_o, 1);
      chk("to.sticky_pass", bus_a.pass_o, 0);

      // Completion on the same edge the timeout would fire: completion wins.
      do_reset();
      step(2);
      pulse(0, 0, 32'd1);
      step(60);
      pulse(0, 1, 32'd1);
      chk("sim.done_e64", bus_a.done_o, 0);
      chk("sim.timeout_e64", bus_a.timeout_o, 0);
      step(3);
      chk("sim.done_e67", bus_a.done_o, 0);
      step(1);
      chk("sim.pass_e68", bus_a.pass_o, 1);
      chk("sim.timeout_e68", bus_a.timeout_o, 0);

      // Reset in the middle of DRAIN, then a fresh run with the original latency.
      do_reset();
      step(5);
      pulse(0, 0, 32'd1);
      pulse(0, 1, 32'd5);
      step(1);
      do_reset();
      chk("rst.done", bus_a.done_o, 0);
      chk("rst.fail", bus_a.fail_o, 0);
      chk("rst.cycle_cnt", bus_a.cycle_cnt_o, 0);
      step(10);
      pulse(0, 0, 32'd1);
      step(9);
      pulse(0, 1, 32'd1);
      step(3);
      chk("rst.done_e24", bus_a.done_o, 0);
      step(1);
      chk("rst.pass_e25", bus_a.pass_o, 1);

      // Multi-fail priority on the four-hart instance.
      do_reset();
      step(2);
      gpv[1][0] = 32'd1; gpv[1][1] = 32'd1; gpv[1][2] = 32'd5; gpv[1][3] = 32'd5;
      ec[1] = 4'hf;
      step(1);
      ec[1] = 4'h0;
      step(2);
      chk("prio.done_e5", bus_b.done_o, 0);
      step(1);
      chk("prio.fail_e6", bus_b.fail_o, 1);
      chk("prio.fail_hart_e6", bus_b.fail_hart_o, 2);
      chk("prio.fail_code_e6", bus_b.fail_code_o, 2);
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
